// File: rtl/ariane_boot_seq.sv
// -----------------------------------------------------------------------------
// ariane_boot_seq
//
// Reset / wake-up sequencer for one Ariane tile. Holds the core in reset while
// the tile SRAMs initialise, optionally waits for the L1.5 wake-up interrupt,
// and services debug-module non-debug resets (ndmreset) once the core runs.
//
// Optional feature macro: ARIANE_BOOT_WAKEUP_INT_EN
//   defined   -> WAKE state and wake_i / wake_seen logic are built; the core is
//                released only after the SRAM-init wait AND a wake-up interrupt.
//   undefined -> wake_i is unused, WAKE is unreachable, INIT goes straight to
//                RUN after InitCycles cycles (legacy fixed-delay behaviour).
//
// Ports
//   clk_i           core clock
//   rst_i           asynchronous, active-high reset
//   wake_i          one-cycle pulse: L1.5 delivered a valid wake-up interrupt
//   ndmreset_req_i  level request from the debug module to reset the core
//   core_rst_no     active-low core reset, registered, to the reset synchronizer
//   boot_done_o     one-cycle pulse on every entry to RUN
//   state_o         current state: INIT=0, WAKE=1, RUN=2, HOLD=3
// -----------------------------------------------------------------------------
module ariane_boot_seq #(
  parameter int unsigned InitCycles    = 128,
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned CntWidth      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wake_i,
  input  logic       ndmreset_req_i,
  output logic       core_rst_no,
  output logic       boot_done_o,
  output logic [1:0] state_o
);

  // Encoding is observable on state_o, so it is fixed.
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Terminal counts; the counter stops here instead of wrapping.
  localparam logic [CntWidth-1:0] INIT_LAST = CntWidth'(InitCycles - 1);
  localparam logic [CntWidth-1:0] HOLD_LAST = CntWidth'(RstHoldCycles - 1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                core_rst_nq, core_rst_nd;
  logic                boot_done_q, boot_done_d;

`ifdef ARIANE_BOOT_WAKEUP_INT_EN
  logic wake_seen_q, wake_seen_d;
`else
  // wake_i has no function in the legacy build.
  logic unused_wake;
  assign unused_wake = wake_i;
`endif

  // NOTE: every always_comb output gets a default first so no path through the
  // case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef ARIANE_BOOT_WAKEUP_INT_EN
    wake_seen_d = wake_seen_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef ARIANE_BOOT_WAKEUP_INT_EN
        wake_seen_d = wake_seen_q | wake_i;
`endif
        if (cnt_q == INIT_LAST) begin
          cnt_d = '0;
`ifdef ARIANE_BOOT_WAKEUP_INT_EN
          // A wake-up landing in the last INIT cycle still counts as seen.
          state_d = (wake_seen_q | wake_i) ? ST_RUN : ST_WAKE;
`else
          state_d = ST_RUN;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAKE: begin
`ifdef ARIANE_BOOT_WAKEUP_INT_EN
        if (wake_i) state_d = ST_RUN;
`else
        // Unreachable without the feature; recover through a full INIT.
        state_d = ST_INIT;
`endif
      end

      ST_RUN: begin
        if (ndmreset_req_i) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        // SRAMs are already initialised, so HOLD only ever returns to RUN.
        if (cnt_q == HOLD_LAST) begin
          if (!ndmreset_req_i) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase

`ifdef ARIANE_BOOT_WAKEUP_INT_EN
    if (state_d == ST_RUN) wake_seen_d = 1'b0;
`endif
  end

  // Output flops are loaded from the next state, so they change on the same
  // edge as state_q and core_rst_no==1 exactly while state_q==RUN.
  assign core_rst_nd = (state_d == ST_RUN);
  assign boot_done_d = (state_d == ST_RUN) && (state_q != ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      core_rst_nq <= 1'b0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_rst_nq <= core_rst_nd;
      boot_done_q <= boot_done_d;
    end
  end

`ifdef ARIANE_BOOT_WAKEUP_INT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wake_seen_q <= 1'b0;
    else       wake_seen_q <= wake_seen_d;
  end
`endif

  assign core_rst_no = core_rst_nq;
  assign boot_done_o = boot_done_q;
  assign state_o     = state_q;

endmodule
